// File: rtl/game_round_ctrl.sv
// game_round_ctrl
//   Round sequencer for a switch-matching reaction game. A start press
//   begins a game. Each round requests a new LED prompt, then gives the
//   player ROUND_TIME seconds to set the switches. A correct answer scores
//   and is followed by a GAP_TIME pause. A wrong answer or a timeout ends
//   the game. The best score is kept until reset.
//
// Ports
//   clk          system clock, rising edge
//   reset_btn    asynchronous active-high reset
//   tick_1hz     one-clk enable pulse once per second
//   start_btn    debounced active-high start level
//   check_valid  one-clk pulse, qualifies is_correct
//   is_correct   1 = switch arrangement matches the prompt
//   choose_flag  one-clk request for a new prompt (PROMPT state)
//   time_left    seconds remaining in PLAY or GAP
//   score        current game score, saturating at SCORE_MAX
//   high_score   best final score since reset
//   round_num    rounds passed this game, saturating at 255
//   playing      high in PROMPT, PLAY and GAP
//   game_over    high in GAME_OVER
module game_round_ctrl #(
  parameter int ROUND_TIME = 15,
  parameter int GAP_TIME   = 5,
  parameter int SCORE_MAX  = 999
) (
  input  logic       clk,
  input  logic       reset_btn,
  input  logic       tick_1hz,
  input  logic       start_btn,
  input  logic       check_valid,
  input  logic       is_correct,
  output logic       choose_flag,
  output logic [5:0] time_left,
  output logic [9:0] score,
  output logic [9:0] high_score,
  output logic [7:0] round_num,
  output logic       playing,
  output logic       game_over
);

  typedef enum logic [2:0] {S_IDLE, S_PROMPT, S_PLAY, S_GAP, S_OVER} state_t;

  localparam logic [5:0]  ROUND_T = 6'(ROUND_TIME);
  localparam logic [5:0]  GAP_T   = 6'(GAP_TIME);
  localparam logic [10:0] SMAX    = 11'(SCORE_MAX);

  state_t     state_q, state_d;
  logic [5:0] time_left_q, time_left_d;
  logic [9:0] score_q, score_d;
  logic [9:0] high_q, high_d;
  logic [7:0] round_q, round_d;
  logic       choose_q, playing_q, over_q;
  logic       start_prev_q, start_armed_q;

  // start_armed_q stays low after reset until the button is seen released,
  // so a button held through reset cannot start a game.
  logic start_evt;
  assign start_evt = start_btn & ~start_prev_q & start_armed_q;

  // Award doubles every five rounds, capped at 16.
  logic [1:0]  lvl;
  logic [10:0] award, sum, score_sat;
  always_comb begin
    if (round_q >= 8'd15)      lvl = 2'd3;
    else if (round_q >= 8'd10) lvl = 2'd2;
    else if (round_q >= 8'd5)  lvl = 2'd1;
    else                       lvl = 2'd0;
    award     = 11'd2 << lvl;
    sum       = {1'b0, score_q} + award;
    score_sat = (sum > SMAX) ? SMAX : sum;
  end

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    score_d     = score_q;
    round_d     = round_q;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_evt) begin
          state_d     = S_PROMPT;
          score_d     = '0;
          round_d     = '0;
          time_left_d = ROUND_T;
        end
      end
      S_PROMPT: state_d = S_PLAY;
      S_PLAY: begin
        // A check in the same cycle as a tick wins; the tick is dropped.
        if (check_valid) begin
          if (is_correct) begin
            score_d     = score_sat[9:0];
            round_d     = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
            time_left_d = GAP_T;
            state_d     = S_GAP;
          end else begin
            state_d = S_OVER;
          end
        end else if (tick_1hz) begin
          if (time_left_q <= 6'd1) begin
            time_left_d = '0;
            state_d     = S_OVER;
          end else begin
            time_left_d = time_left_q - 6'd1;
          end
        end
      end
      S_GAP: begin
        if (tick_1hz) begin
          if (time_left_q <= 6'd1) begin
            state_d     = S_PROMPT;
            time_left_d = ROUND_T;
          end else begin
            time_left_d = time_left_q - 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    high_d = high_q;
    if (state_d == S_OVER && state_q != S_OVER && score_d > high_q)
      high_d = score_d;
  end

  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) begin
      state_q       <= S_IDLE;
      time_left_q   <= '0;
      score_q       <= '0;
      high_q        <= '0;
      round_q       <= '0;
      choose_q      <= 1'b0;
      playing_q     <= 1'b0;
      over_q        <= 1'b0;
      start_prev_q  <= 1'b0;
      start_armed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      time_left_q   <= time_left_d;
      score_q       <= score_d;
      high_q        <= high_d;
      round_q       <= round_d;
      choose_q      <= (state_d == S_PROMPT);
      playing_q     <= (state_d == S_PROMPT) || (state_d == S_PLAY) || (state_d == S_GAP);
      over_q        <= (state_d == S_OVER);
      start_prev_q  <= start_btn;
      start_armed_q <= start_armed_q | ~start_btn;
    end
  end

  assign choose_flag = choose_q;
  assign time_left   = time_left_q;
  assign score       = score_q;
  assign high_score  = high_q;
  assign round_num   = round_q;
  assign playing     = playing_q;
  assign game_over   = over_q;

endmodule
